cdtimer: RTL and testbench
==========================

CDTIMER -- requirements
Module: cdtimer

Interface
REQ-001 Parameter CLOCK_HZ, default 27_000_000, system clock frequency in Hz.
REQ-002 Parameter TICK_HZ, default 1000, countdown decrement rate in Hz.
REQ-003 Parameter BASE_ADDR, default 'h002, byte address of the count register; the config register is at BASE_ADDR+2.
REQ-004 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mem_addr  input  `ADDR_WIDTH  byte address from the CPU bus.
REQ-007 rd_mem  input  1  read strobe for explicit loads.
REQ-008 wr_mem  input  1  write strobe.
REQ-009 byt  input  1  byte access when 1; mem_addr[0] selects the lane.
REQ-010 wr_data  input  16  write data; for byte writes with mem_addr[0]=1 the data is in [15:8], otherwise in [7:0].
REQ-011 rd_data  output  16  registered read data; 0 when no register is selected, so the bus can be OR-combined.
REQ-012 irq  output  1  level interrupt request, equal to IF & IE.

Function
REQ-013 Register map:
- BASE_ADDR (count): 16-bit remaining-tick counter.
- BASE_ADDR+2 (config): bit0 IF, bit1 IE; bits 15:2 read as 0 and ignore writes.
REQ-014 Address decode SHALL compare mem_addr[`ADDR_WIDTH-1:1] only; mem_addr[0] is used solely for lane selection.
REQ-015 Reads: with rd_mem=1 and the address decoded in cycle N, rd_data SHALL present the full 16-bit register in cycle N+1; byte extraction is done by the CPU.
REQ-016 rd_data SHALL be 0 in every cycle that does not follow a decoded read.
REQ-017 Word writes (byt=0) SHALL update all 16 bits of the target register.
REQ-018 Byte writes:
- Lane 0 updates bits [7:0] from wr_data[7:0].
- Lane 1 updates bits [15:8] from wr_data[15:8].
- Byte writes to config lane 1 have no effect.
REQ-019 Prescaler: a down-counter of width clog2(CLOCK_HZ/TICK_HZ). It reloads to CLOCK_HZ/TICK_HZ-1 on reset and on any count write, and emits a one-cycle tick when it reaches 0, then reloads.
REQ-020 On a tick with count>0, count SHALL decrement by 1; on the transition 1->0, IF SHALL be set in the same edge.
REQ-021 With count=0, ticks SHALL leave count at 0 and SHALL NOT set IF again.
REQ-022 Writing IF=0 clears IF; writing IF=1 SHALL also set IF (software interrupt).
REQ-023 Simultaneous events:
- A count write in the same cycle as a tick: the write wins and the decrement is lost.
- A config write clearing IF in the same cycle as expiry: IF ends set.
REQ-024 irq SHALL be combinational from the IF and IE flops, with no added latency.
REQ-025 A simultaneous rd_mem and wr_mem to the same register SHALL return the pre-write value in rd_data.

Reset
REQ-026 On rst_n=0 the block SHALL asynchronously clear count, IF, IE, rd_data and the reload latch, and preset the prescaler to CLOCK_HZ/TICK_HZ-1; irq is 0.
REQ-027 Reset asserted mid-countdown SHALL abort the countdown with no IF set; operation resumes on the first clk edge after rst_n rises.

Configuration
REQ-028 Macro CDTIMER_AUTORELOAD_EN.
- When defined, every count write also stores the value into a 16-bit reload latch. On a 1->0 expiry, count SHALL load the reload latch in the same edge instead of 0, and set IF. A latch value of 0 leaves count at 0.
- When undefined, no reload latch exists and count stops at 0.

Verification
Benches use CLOCK_HZ=10_000 and TICK_HZ=1000, giving a 10-cycle tick.
REQ-029 Reset: drive rst_n=0 mid-countdown -> count=0, IF=0, IE=0, rd_data=0, irq=0 immediately.
REQ-030 Countdown: word-write 3 to 002h, write 0002h to 004h -> IF=1 and irq=1 exactly 30 cycles after the write; count then stays 0.
REQ-031 Byte lanes and read latency:
- Byte-write 12h (data 1200h) to 003h, then 34h to 002h -> word read of 002h returns 1234h in the cycle after rd_mem.
- Byte-write to 005h -> config unchanged.
REQ-032 Collisions:
- Write count=5 in the same cycle a tick fires -> count=5 and the prescaler restarts.
- Clear IF in the expiry cycle -> IF=1.
REQ-033 CDTIMER_AUTORELOAD_EN defined: write 2 -> IF set every 20 cycles and count reloads to 2; undefined -> a single expiry, count stays 0.
REQ-034 Software interrupt: with IE=1, write 0003h to 004h -> irq=1 on the next cycle; write 0002h -> irq=0.

Source files
------------

// File: rtl/cdtimer.sv
// cdtimer: memory-mapped countdown timer with a level interrupt.
//   BASE_ADDR   : 16-bit count register, decremented once per tick.
//   BASE_ADDR+2 : config register, bit0 IF (expired flag), bit1 IE (enable).
// A prescaler divides clk down to TICK_HZ. When count goes 1->0, IF is set.
// irq = IF & IE.
// Optional feature macro: CDTIMER_AUTORELOAD_EN. When defined, every count
// write is also stored in a reload latch. On expiry, count reloads from that
// latch instead of stopping at 0.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module cdtimer #(
  parameter int                      CLOCK_HZ  = 27_000_000,
  parameter int                      TICK_HZ   = 1000,
  parameter logic [`ADDR_WIDTH-1:0]  BASE_ADDR = 'h002
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [`ADDR_WIDTH-1:0] mem_addr,
  input  logic                   rd_mem,
  input  logic                   wr_mem,
  input  logic                   byt,
  input  logic [15:0]            wr_data,
  output logic [15:0]            rd_data,
  output logic                   irq
);

  localparam int               AW           = `ADDR_WIDTH;
  localparam int               DIV          = CLOCK_HZ / TICK_HZ;
  localparam int               PW           = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRESC_RELOAD = PW'(DIV - 1);
  localparam logic [AW-1:0]    CFG_ADDR     = BASE_ADDR + AW'(2);

  // Bus handshake: rd_mem and wr_mem are single-cycle qualifiers. The bus
  // never stalls. A read sampled on edge N returns data after that edge, so
  // the data is valid for the whole of cycle N+1. In every other cycle
  // rd_data is 0, so several peripherals can be OR-ed onto one bus.
  // A write is committed on the edge where wr_mem is sampled high.

  logic [15:0]   count_q, count_nxt;
  logic          if_q, if_nxt;
  logic          ie_q, ie_nxt;
  logic [PW-1:0] presc_q;
  logic          tick;
  logic          expire;
  logic          sel_cnt, sel_cfg;
  logic          lane_lo_en, lane_hi_en;
  logic          wr_cnt, wr_cfg;
  logic [15:0]   cnt_wr_val;

`ifdef CDTIMER_AUTORELOAD_EN
  logic [15:0]   reload_q;
`endif

  // Decode ignores bit 0; that bit only picks the byte lane.
  assign sel_cnt    = (mem_addr[AW-1:1] == BASE_ADDR[AW-1:1]);
  assign sel_cfg    = (mem_addr[AW-1:1] == CFG_ADDR[AW-1:1]);
  assign lane_lo_en = ~byt | ~mem_addr[0];
  assign lane_hi_en = ~byt |  mem_addr[0];
  assign wr_cnt     = wr_mem & sel_cnt;
  // Config has no writable bits in the upper lane. A lane-1 byte write is a no-op.
  assign wr_cfg     = wr_mem & sel_cfg & lane_lo_en;

  assign cnt_wr_val = {lane_hi_en ? wr_data[15:8] : count_q[15:8],
                       lane_lo_en ? wr_data[7:0]  : count_q[7:0]};

  assign tick = (presc_q == '0);
  assign irq  = if_q & ie_q;

  // Prescaler: free-running divider, restarted by any count write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          presc_q <= PRESC_RELOAD;
    else if (wr_cnt)     presc_q <= PRESC_RELOAD;
    else if (tick)       presc_q <= PRESC_RELOAD;
    else                 presc_q <= presc_q - PW'(1);
  end

  // Next-state for count and flags. A count write beats a tick. Expiry beats
  // a software clear of IF.
  always_comb begin
    count_nxt = count_q;
    if_nxt    = if_q;
    ie_nxt    = ie_q;
    expire    = 1'b0;
    if (wr_cnt) begin
      count_nxt = cnt_wr_val;
    end else if (tick && (count_q != 16'd0)) begin
      count_nxt = count_q - 16'd1;
      if (count_q == 16'd1) begin
        expire = 1'b1;
`ifdef CDTIMER_AUTORELOAD_EN
        count_nxt = reload_q;
`endif
      end
    end
    if (wr_cfg) begin
      if_nxt = wr_data[0];
      ie_nxt = wr_data[1];
    end
    if (expire) if_nxt = 1'b1;
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
      if_q    <= 1'b0;
      ie_q    <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if_q    <= if_nxt;
      ie_q    <= ie_nxt;
    end
  end

`ifdef CDTIMER_AUTORELOAD_EN
  // Reload latch: holds the value last written to count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      reload_q <= 16'd0;
    else if (wr_cnt) reload_q <= cnt_wr_val;
  end
`endif

  // Registered read port. It captures the pre-write value when a read and a
  // write hit the same register in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 rd_data <= 16'd0;
    else if (rd_mem && sel_cnt) rd_data <= count_q;
    else if (rd_mem && sel_cfg) rd_data <= {14'd0, ie_q, if_q};
    else                        rd_data <= 16'd0;
  end

endmodule

// File: tb/tb_cdtimer.sv
// Testbench for cdtimer. It runs with a 10-cycle tick (CLOCK_HZ=10000,
// TICK_HZ=1000). Reads push the expected value into exp_q. A monitor
// compares rd_data on the falling edge of the cycle after each read, and
// checks that rd_data is 0 in every other cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module tb_cdtimer;

`ifdef CDTIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  localparam logic [15:0] A_CNT = 16'h002;
  localparam logic [15:0] A_CFG = 16'h004;

  logic                   clk;
  logic                   rst_n;
  logic [`ADDR_WIDTH-1:0] mem_addr;
  logic                   rd_mem;
  logic                   wr_mem;
  logic                   byt;
  logic [15:0]            wr_data;
  logic [15:0]            rd_data;
  logic                   irq;

  logic [15:0] exp_q[$];
  string       name_q[$];
  logic        rd_pend_q;
  int          n_checks;
  int          n_pass;

  cdtimer #(
    .CLOCK_HZ (10_000),
    .TICK_HZ  (1000),
    .BASE_ADDR('h002)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_addr(mem_addr),
    .rd_mem  (rd_mem),
    .wr_mem  (wr_mem),
    .byt     (byt),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq     (irq)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparison helper.
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Driver tasks. Each one starts just after a falling edge and returns at the next falling edge.
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic b);
    mem_addr = a; wr_data = d; byt = b; wr_mem = 1'b1;
    @(negedge clk);
    wr_mem = 1'b0; byt = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] e, input string nm);
    mem_addr = a; rd_mem = 1'b1;
    exp_q.push_back(e); name_q.push_back(nm);
    @(negedge clk);
    rd_mem = 1'b0;
  endtask

  task automatic rw(input logic [15:0] a, input logic [15:0] d, input logic [15:0] e,
                    input string nm);
    mem_addr = a; wr_data = d; byt = 1'b0; rd_mem = 1'b1; wr_mem = 1'b1;
    exp_q.push_back(e); name_q.push_back(nm);
    @(negedge clk);
    rd_mem = 1'b0; wr_mem = 1'b0;
  endtask

  // Tracks that a read was accepted on the last rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_pend_q <= 1'b0;
    else        rd_pend_q <= rd_mem;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    logic [15:0] e;
    string       nm;
    if (rd_pend_q) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL sb_underflow: got %h expected nothing queued", rd_data);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk(nm, rd_data, e);
      end
    end else begin
      chk("rd_idle_zero", rd_data, 16'h0000);
    end
  end

  // Stimulus.
  initial begin
    n_checks = 0; n_pass = 0;
    mem_addr = '0; rd_mem = 1'b0; wr_mem = 1'b0; byt = 1'b0; wr_data = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_irq", {15'd0, irq}, 16'h0000);
    chk("reset_rd_data", rd_data, 16'h0000);
    wait_cyc(3);
    rst_n = 1'b1;

    rd(A_CNT, 16'h0000, "reset_count");
    rd(A_CFG, 16'h0000, "reset_cfg");

    // Byte lanes and read latency.
    wr(16'h003, 16'h1200, 1'b1);
    wr(16'h002, 16'h0034, 1'b1);
    rd(A_CNT, 16'h1234, "byte_lanes");
    wr(16'h005, 16'hFF03, 1'b1);
    rd(A_CFG, 16'h0000, "cfg_lane1_ignored");
    wr(16'h004, 16'h0002, 1'b1);
    rd(A_CFG, 16'h0002, "cfg_lane0_byte");
    chk("irq_ie_only", {15'd0, irq}, 16'h0000);

    // Software interrupt.
    wr(A_CFG, 16'h0003, 1'b0);
    chk("irq_sw_set", {15'd0, irq}, 16'h0001);
    wr(A_CFG, 16'h0002, 1'b0);
    chk("irq_sw_clear", {15'd0, irq}, 16'h0000);
    rd(16'h005, 16'h0002, "cfg_odd_addr");
    wr(A_CFG, 16'h0000, 1'b0);

    // Read and write to the same register in one cycle.
    wr(A_CNT, 16'h00AA, 1'b0);
    rw(A_CNT, 16'h0055, 16'h00AA, "rw_pre_value");
    rd(A_CNT, 16'h0055, "rw_post_value");

    // Countdown: count=3, IE=1. IF is set 30 cycles after the count write.
    wr(A_CNT, 16'h0003, 1'b0);
    wr(A_CFG, 16'h0002, 1'b0);
    wait_cyc(28);
    chk("irq_before_expiry", {15'd0, irq}, 16'h0000);
    wait_cyc(1);
    chk("irq_at_expiry", {15'd0, irq}, 16'h0001);
    rd(A_CNT, AR ? 16'h0003 : 16'h0000, "count_after_expiry");
    rd(A_CFG, 16'h0003, "cfg_after_expiry");
    wait_cyc(30);
    rd(A_CNT, AR ? 16'h0003 : 16'h0000, "count_holds");
    wr(A_CFG, 16'h0000, 1'b0);

    // A count write restarts the prescaler.
    wr(A_CNT, 16'h0009, 1'b0);
    wait_cyc(4);
    wr(A_CNT, 16'h0007, 1'b0);
    wait_cyc(9);
    rd(A_CNT, 16'h0007, "presc_restart_before");
    rd(A_CNT, 16'h0006, "presc_restart_after");
    // A count write on the tick edge wins.
    wait_cyc(8);
    wr(A_CNT, 16'h0005, 1'b0);
    rd(A_CNT, 16'h0005, "write_beats_tick");
    wait_cyc(8);
    rd(A_CNT, 16'h0005, "tick_after_collision_before");
    rd(A_CNT, 16'h0004, "tick_after_collision_after");

    // Clearing IF on the expiry edge leaves IF set.
    wr(A_CFG, 16'h0000, 1'b0);
    wr(A_CNT, 16'h0001, 1'b0);
    wait_cyc(9);
    wr(A_CFG, 16'h0000, 1'b0);
    rd(A_CFG, 16'h0001, "expiry_beats_clear");
    rd(A_CNT, AR ? 16'h0001 : 16'h0000, "count_after_collision");

    // Single expiry, or periodic expiry with auto-reload.
    wr(A_CNT, 16'h0002, 1'b0);
    wr(A_CFG, 16'h0000, 1'b0);
    wait_cyc(19);
    rd(A_CFG, 16'h0001, "first_expiry");
    wr(A_CFG, 16'h0000, 1'b0);
    rd(A_CNT, AR ? 16'h0002 : 16'h0000, "reload_value");
    wait_cyc(16);
    rd(A_CFG, 16'h0000, "second_expiry_before");
    rd(A_CFG, AR ? 16'h0001 : 16'h0000, "second_expiry");
    rd(A_CNT, AR ? 16'h0002 : 16'h0000, "second_reload_value");

    // Reset mid-countdown while a read is in flight and irq is high.
    wr(A_CNT, 16'h0032, 1'b0);
    wr(A_CFG, 16'h0003, 1'b0);
    chk("irq_before_reset", {15'd0, irq}, 16'h0001);
    wait_cyc(3);
    mem_addr = A_CNT; rd_mem = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0; rd_mem = 1'b0;
    #1;
    chk("midrun_reset_rd_data", rd_data, 16'h0000);
    chk("midrun_reset_irq", {15'd0, irq}, 16'h0000);
    wait_cyc(3);
    rst_n = 1'b1;
    rd(A_CNT, 16'h0000, "midrun_reset_count");
    rd(A_CFG, 16'h0000, "midrun_reset_cfg");
    wait_cyc(60);
    rd(A_CFG, 16'h0000, "aborted_no_if");
    rd(A_CNT, 16'h0000, "aborted_count");

    wait_cyc(2);
    chk("sb_drain", 16'(exp_q.size()), 16'h0000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
